gray_counter_nbit: RTL and testbench



---
 rtl/gray_pkg.sv | 28 ++
 rtl/gray_to_binary_nbit.sv | 18 +
 rtl/gray_counter_nbit.sv | 92 +++++++++
 tb/tb_gray_counter_nbit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared helpers for Gray-coded counters: width-generic conversion and
// terminal-value constants, plus the step kinds the counter core decodes.
package gray_pkg;

  // Widest counter these helpers support; callers zero-extend into this.
  localparam int unsigned GRAY_MAX_W = 64;

  typedef logic [GRAY_MAX_W-1:0] gray_vec_t;

  // What the counter does at the next edge (reset is handled separately).
  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_LOAD = 2'd1,
    STEP_UP   = 2'd2,
    STEP_DOWN = 2'd3
  } step_t;

  // Binary to reflected Gray; upper zero-extension bits stay zero.
  function automatic gray_vec_t bin2gray(input gray_vec_t b);
    return b ^ (b >> 1);
  endfunction

  // All-ones terminal value for a counter of width w.
  function automatic gray_vec_t all_ones(input int unsigned w);
    return {GRAY_MAX_W{1'b1}} >> (GRAY_MAX_W - w);
  endfunction

endpackage

// File: rtl/gray_to_binary_nbit.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits at or above its position (prefix XOR from the MSB).
module gray_to_binary_nbit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // b[k] = g[W-1] ^ ... ^ g[k], expressed as a reduction of the shifted code
  always_comb begin
    o_bin = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      o_bin[k] = ^(i_gray >> k);
    end
  end

endmodule

// File: rtl/gray_counter_nbit.sv
// Up/down binary counter with registered Gray output, parallel load in
// binary or Gray form, and a one-cycle wrap pulse on terminal rollover.
module gray_counter_nbit
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(all_ones(WIDTH));

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic [WIDTH-1:0] w_gray_conv;
  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_wrap_next;
  step_t            w_step;

  gray_to_binary_nbit #(
    .WIDTH (WIDTH)
  ) u_g2b (
    .i_gray (load_val),
    .o_bin  (w_gray_conv)
  );

  // Load value in binary regardless of how it was presented
  always_comb begin
    w_load_bin = load_is_gray ? w_gray_conv : load_val;
  end

  // Decode the operation for this edge: load beats count beats hold
  always_comb begin
    w_step = STEP_HOLD;
    if (load) begin
      w_step = STEP_LOAD;
    end else if (en) begin
      w_step = up ? STEP_UP : STEP_DOWN;
    end
  end

  // Next binary count, wrap flag, and Gray code of the next count
  always_comb begin
    w_next      = r_bin;
    w_wrap_next = 1'b0;
    unique case (w_step)
      STEP_LOAD: w_next = w_load_bin;
      STEP_UP: begin
        w_next      = r_bin + 1'b1;
        w_wrap_next = (r_bin == MAX_VAL);
      end
      STEP_DOWN: begin
        w_next      = r_bin - 1'b1;
        w_wrap_next = (r_bin == '0);
      end
      default: ;
    endcase
    // Gray is derived from the next value so it is registered alongside bin
    w_gray_next = WIDTH'(bin2gray(GRAY_MAX_W'(w_next)));
  end

  // Counter state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bin_out  = r_bin;
  assign gray_out = r_gray;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_gray_counter_nbit.sv
// Bench for gray_counter_nbit: directed WIDTH=4 and WIDTH=2 sequences plus a
// WIDTH=8 random run against an arithmetic reference model.
module tb_gray_counter_nbit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=4 instance
  logic       rst4, en4, up4, ld4, lg4;
  logic [3:0] lv4, b4, g4;
  logic       w4;

  // WIDTH=2 instance
  logic       rst2, en2, up2, ld2, lg2;
  logic [1:0] lv2, b2, g2;
  logic       w2;

  // WIDTH=8 instance
  logic       rst8, en8, up8, ld8, lg8;
  logic [7:0] lv8, b8, g8;
  logic       w8;

  gray_counter_nbit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .up(up4), .load(ld4), .load_is_gray(lg4),
    .load_val(lv4), .bin_out(b4), .gray_out(g4), .wrap(w4)
  );

  gray_counter_nbit #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .up(up2), .load(ld2), .load_is_gray(lg2),
    .load_val(lv2), .bin_out(b2), .gray_out(g2), .wrap(w2)
  );

  gray_counter_nbit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .up(up8), .load(ld8), .load_is_gray(lg8),
    .load_val(lv8), .bin_out(b8), .gray_out(g8), .wrap(w8)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: outputs sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned ref_gray(input int unsigned v);
    return v ^ (v >> 1);
  endfunction

  // Gray decode by search: the binary value whose Gray code matches
  function automatic int unsigned ref_g2b(input int unsigned g, input int unsigned w);
    for (int unsigned v = 0; v < (32'd1 << w); v++) begin
      if (ref_gray(v) == g) return v;
    end
    return 0;
  endfunction

  // WIDTH=8 reference model state
  int unsigned m_cnt;
  bit          m_wrap;
  bit          m_step;
  int unsigned m_prev_gray;

  initial begin
    rst4 = 1'b1; en4 = 1'b0; up4 = 1'b1; ld4 = 1'b0; lg4 = 1'b0; lv4 = '0;
    rst2 = 1'b1; en2 = 1'b0; up2 = 1'b1; ld2 = 1'b0; lg2 = 1'b0; lv2 = '0;
    rst8 = 1'b1; en8 = 1'b0; up8 = 1'b1; ld8 = 1'b0; lg8 = 1'b0; lv8 = '0;
    @(negedge clk);
    tick();
    chk("rst_bin", 8'(b4), 8'd0);
    chk("rst_gray", 8'(g4), 8'd0);
    chk("rst_wrap", 8'(w4), 8'd0);

    // Count up through a full cycle
    rst4 = 1'b0; rst2 = 1'b0;
    en4 = 1'b1; up4 = 1'b1;
    begin
      int unsigned prev_g;
      prev_g = 0;
      for (int i = 1; i <= 16; i++) begin
        int unsigned e;
        tick();
        e = i % 16;
        chk($sformatf("up_bin[%0d]", i), 8'(b4), 8'(e));
        chk($sformatf("up_gray[%0d]", i), 8'(g4), 8'(ref_gray(e)));
        chk($sformatf("up_wrap[%0d]", i), 8'(w4), (i == 16) ? 8'd1 : 8'd0);
        chk($sformatf("up_ham[%0d]", i), 8'($countones(g4 ^ 4'(prev_g))), 8'd1);
        prev_g = ref_gray(e);
      end
    end

    // Load binary 0, then count down twice
    en4 = 1'b0; ld4 = 1'b1; lg4 = 1'b0; lv4 = 4'd0;
    tick();
    chk("ld0_bin", 8'(b4), 8'd0);
    chk("ld0_wrap", 8'(w4), 8'd0);
    ld4 = 1'b0; en4 = 1'b1; up4 = 1'b0;
    tick();
    chk("dn1_bin", 8'(b4), 8'd15);
    chk("dn1_gray", 8'(g4), 8'b1000);
    chk("dn1_wrap", 8'(w4), 8'd1);
    tick();
    chk("dn2_bin", 8'(b4), 8'd14);
    chk("dn2_gray", 8'(g4), 8'b1001);
    chk("dn2_wrap", 8'(w4), 8'd0);

    // Gray-form load
    en4 = 1'b0; ld4 = 1'b1; lg4 = 1'b1; lv4 = 4'b1101;
    tick();
    chk("ldg_bin", 8'(b4), 8'd9);
    chk("ldg_gray", 8'(g4), 8'b1101);
    chk("ldg_wrap", 8'(w4), 8'd0);

    // Load and enable together: load wins, no wrap from loading max
    en4 = 1'b1; up4 = 1'b1; ld4 = 1'b1; lg4 = 1'b0; lv4 = 4'hF;
    tick();
    chk("ldEn_bin", 8'(b4), 8'd15);
    chk("ldEn_wrap", 8'(w4), 8'd0);
    ld4 = 1'b0;
    tick();
    chk("ldEn_next_bin", 8'(b4), 8'd0);
    chk("ldEn_next_gray", 8'(g4), 8'd0);
    chk("ldEn_next_wrap", 8'(w4), 8'd1);

    // Reset beats a simultaneous load while counting
    en4 = 1'b0; ld4 = 1'b1; lv4 = 4'd7;
    tick();
    chk("ld7_bin", 8'(b4), 8'd7);
    rst4 = 1'b1; en4 = 1'b1; ld4 = 1'b1; lv4 = 4'd3;
    tick();
    chk("rstld_bin", 8'(b4), 8'd0);
    chk("rstld_gray", 8'(g4), 8'd0);
    chk("rstld_wrap", 8'(w4), 8'd0);
    rst4 = 1'b0; ld4 = 1'b0; en4 = 1'b1; up4 = 1'b1;
    tick();
    chk("resume_bin", 8'(b4), 8'd1);
    chk("resume_gray", 8'(g4), 8'd1);

    // Hold: outputs stay, wrap stays low
    en4 = 1'b0;
    tick();
    chk("hold_bin", 8'(b4), 8'd1);
    chk("hold_wrap", 8'(w4), 8'd0);

    // WIDTH=2 back-to-back wraps with alternating direction
    en2 = 1'b1; up2 = 1'b0;
    tick();
    chk("w2_a_bin", 8'(b2), 8'd3);
    chk("w2_a_wrap", 8'(w2), 8'd1);
    up2 = 1'b1;
    tick();
    chk("w2_b_bin", 8'(b2), 8'd0);
    chk("w2_b_wrap", 8'(w2), 8'd1);
    up2 = 1'b0;
    tick();
    chk("w2_c_bin", 8'(b2), 8'd3);
    chk("w2_c_gray", 8'(g2), 8'b10);
    chk("w2_c_wrap", 8'(w2), 8'd1);
    en2 = 1'b0;

    // WIDTH=8 random regression
    rst8 = 1'b0;
    m_cnt = 0; m_wrap = 1'b0; m_prev_gray = 0;
    for (int c = 0; c < 10000; c++) begin
      rst8 = ($urandom_range(199) == 0);
      ld8  = ($urandom_range(9) == 0);
      lg8  = ($urandom_range(1) == 1);
      lv8  = 8'($urandom_range(255));
      en8  = ($urandom_range(3) != 0);
      up8  = ($urandom_range(1) == 1);
      tick();
      m_step = 1'b0;
      if (rst8) begin
        m_cnt = 0; m_wrap = 1'b0;
      end else if (ld8) begin
        m_cnt  = lg8 ? ref_g2b(int'(lv8), 8) : int'(lv8);
        m_wrap = 1'b0;
      end else if (en8) begin
        m_step = 1'b1;
        if (up8) begin
          m_wrap = (m_cnt == 255);
          m_cnt  = (m_cnt + 1) % 256;
        end else begin
          m_wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + 255) % 256;
        end
      end else begin
        m_wrap = 1'b0;
      end
      chk($sformatf("r8_bin@%0d", c), b8, 8'(m_cnt));
      chk($sformatf("r8_gray@%0d", c), g8, 8'(ref_gray(m_cnt)));
      chk($sformatf("r8_wrap@%0d", c), 8'(w8), 8'(m_wrap));
      if (m_step) begin
        chk($sformatf("r8_ham@%0d", c), 8'($countones(g8 ^ 8'(m_prev_gray))), 8'd1);
      end
      m_prev_gray = ref_gray(m_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
